// File: rtl/alu_seq_n_bit.sv
// Registered N-bit ALU with a valid/ready input, persistent C/Z/N/V flags, carry chaining
// and an iterative shift-add unsigned multiplier that holds off new work while it runs.
module alu_seq_n_bit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CB_in,
    input  logic         Use_flag_cb,
    input  logic [3:0]   Mode,
    output logic         out_valid,
    output logic [N-1:0] Result,
    output logic [N-1:0] Result_hi,
    output logic         CB_out,
    output logic         Zero,
    output logic         Neg,
    output logic         Ovf
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;
    localparam int         CW     = $clog2(N + 1);

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4, OP_NOT = 4'h5, OP_INC = 4'h6, OP_DEC  = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA, OP_ROL  = 4'hB;
    localparam logic [3:0] OP_ROR = 4'hC, OP_MUL = 4'hD, OP_CMP = 4'hE, OP_PASS = 4'hF;

    logic [0:0]     state_q, state_d;
    logic [N-1:0]   result_q, result_hi_q, mcand_q;
    logic [2*N-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q;
    logic           c_q, z_q, n_q, v_q, out_valid_q;

    logic                accept, cin, mul_last;
    logic [N:0]          sum, diff, inc, dec, mul_sum;
    logic signed [N-1:0] asr_s;
    logic [N-1:0]        alu_r;
    logic                alu_c, alu_v;

    function automatic logic add_ovf(input logic a_m, input logic b_m, input logic r_m);
        return (a_m == b_m) && (r_m != a_m);
    endfunction

    function automatic logic sub_ovf(input logic a_m, input logic b_m, input logic r_m);
        return (a_m != b_m) && (r_m != a_m);
    endfunction

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign cin      = Use_flag_cb ? c_q : CB_in;

    // The N+1-bit results carry the carry-out (or borrow) in their top bit.
    assign sum   = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, cin};
    assign diff  = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, cin};
    assign inc   = {1'b0, A} + {{N{1'b0}}, 1'b1};
    assign dec   = {1'b0, A} - {{N{1'b0}}, 1'b1};
    assign asr_s = $signed(A) >>> 1;

    // Multiplier keeps the multiplier in the low half of prod_q; it shifts out as the product shifts in.
    assign mul_sum  = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    assign prod_d   = {mul_sum, prod_q[N-1:1]};
    assign mul_last = (cnt_q == CW'(1));

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (Mode)
            OP_ADD:         begin alu_r = sum[N-1:0];  alu_c = sum[N];  alu_v = add_ovf(A[N-1], B[N-1], sum[N-1]);  end
            OP_SUB, OP_CMP: begin alu_r = diff[N-1:0]; alu_c = diff[N]; alu_v = sub_ovf(A[N-1], B[N-1], diff[N-1]); end
            OP_AND:         alu_r = A & B;
            OP_OR:          alu_r = A | B;
            OP_XOR:         alu_r = A ^ B;
            OP_NOT:         alu_r = ~A;
            OP_INC:         begin alu_r = inc[N-1:0]; alu_c = inc[N]; alu_v = ~A[N-1] & inc[N-1]; end
            OP_DEC:         begin alu_r = dec[N-1:0]; alu_c = dec[N]; alu_v = A[N-1] & ~dec[N-1]; end
            OP_SHL:         begin alu_r = {A[N-2:0], 1'b0};  alu_c = A[N-1]; end
            OP_SHR:         begin alu_r = {1'b0, A[N-1:1]};  alu_c = A[0];   end
            OP_ASR:         begin alu_r = $unsigned(asr_s);  alu_c = A[0];   end
            OP_ROL:         begin alu_r = {A[N-2:0], cin};   alu_c = A[N-1]; end
            OP_ROR:         begin alu_r = {cin, A[N-1:1]};   alu_c = A[0];   end
            OP_PASS:        alu_r = B;
            default:        ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (accept && Mode == OP_MUL) state_d = S_MUL;
        end else if (mul_last) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (accept && Mode == OP_MUL) begin
                    mcand_q <= A;
                    prod_q  <= {{N{1'b0}}, B};
                    cnt_q   <= CW'(N);
                end else if (accept) begin
                    c_q         <= alu_c;
                    z_q         <= (alu_r == '0);
                    n_q         <= alu_r[N-1];
                    v_q         <= alu_v;
                    out_valid_q <= 1'b1;
                    if (Mode != OP_CMP) begin
                        result_q    <= alu_r;
                        result_hi_q <= '0;
                    end
                end
            end else begin
                prod_q <= prod_d;
                cnt_q  <= cnt_q - CW'(1);
                if (mul_last) begin
                    result_q    <= prod_d[N-1:0];
                    result_hi_q <= prod_d[2*N-1:N];
                    c_q         <= |prod_d[2*N-1:N];
                    z_q         <= (prod_d == '0);
                    n_q         <= prod_d[2*N-1];
                    v_q         <= 1'b0;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Result_hi = result_hi_q;
    assign CB_out    = c_q;
    assign Zero      = z_q;
    assign Neg       = n_q;
    assign Ovf       = v_q;
endmodule

// File: tb/tb_alu_seq_n_bit.sv
// Scoreboard bench for alu_seq_n_bit (N=4): the driver pushes model predictions, the monitor
// pops one per out_valid pulse; directed cases add fixed-value checks.
module tb_alu_seq_n_bit;
    localparam int NW = 4;
    localparam int M  = 1 << NW;

    typedef logic [2*NW+3:0] exp_t;   // {Result_hi, Result, C, Z, N, V}

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, CB_in = 1'b0, Use_flag_cb = 1'b0;
    logic [NW-1:0] A = '0, B = '0;
    logic [3:0]    Mode = '0;
    logic          in_ready, out_valid, CB_out, Zero, Neg, Ovf;
    logic [NW-1:0] Result, Result_hi;

    alu_seq_n_bit #(.N(NW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .CB_in(CB_in), .Use_flag_cb(Use_flag_cb), .Mode(Mode),
        .out_valid(out_valid), .Result(Result), .Result_hi(Result_hi),
        .CB_out(CB_out), .Zero(Zero), .Neg(Neg), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    int   n_checks = 0, n_fail = 0;
    exp_t exp_q[$];
    int   m_res = 0, m_hi = 0;
    bit   m_c = 1'b0;

    // Reference model in plain integer arithmetic; also tracks held result and the C flag.
    function automatic exp_t model(input int mode, input int a, input int b, input int cin);
        int sa = (a >= M/2) ? a - M : a;
        int sb = (b >= M/2) ? b - M : b;
        int r = 0, hi = 0, full = 0, sv = 0, ro, ho;
        bit c = 1'b0, v = 1'b0, z, n;
        case (mode)
            0:      begin full = a + b + cin; r = full % M; c = (full >= M); sv = sa + sb + cin; v = (sv >= M/2 || sv < -M/2); end
            1, 14:  begin full = a - b - cin; r = (full + 2*M) % M; c = (a < b + cin); sv = sa - sb - cin; v = (sv >= M/2 || sv < -M/2); end
            2:      r = a & b;
            3:      r = a | b;
            4:      r = a ^ b;
            5:      r = M - 1 - a;
            6:      begin full = a + 1; r = full % M; c = (full >= M); sv = sa + 1; v = (sv >= M/2); end
            7:      begin r = (a - 1 + M) % M; c = (a < 1); sv = sa - 1; v = (sv < -M/2); end
            8:      begin r = (a * 2) % M; c = (a >= M/2); end
            9:      begin r = a / 2; c = (a % 2 == 1); end
            10:     begin r = a / 2 + ((a >= M/2) ? M/2 : 0); c = (a % 2 == 1); end
            11:     begin r = (a * 2) % M + cin; c = (a >= M/2); end
            12:     begin r = a / 2 + cin * (M/2); c = (a % 2 == 1); end
            13:     begin r = (a * b) % M; hi = (a * b) / M; c = (hi != 0); end
            default: r = b;
        endcase
        z = (mode == 13) ? (a * b == 0) : (r == 0);
        n = (mode == 13) ? (hi >= M/2) : (r >= M/2);
        if (mode == 14) begin
            ro = m_res; ho = m_hi;
        end else begin
            ro = r; ho = hi; m_res = r; m_hi = hi;
        end
        m_c = c;
        return {NW'(ho), NW'(ro), c, z, n, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [3:0] md, input int a, input int b, input logic cbi, input logic uf);
        int cyc = 0;
        int cin;
        @(negedge clk);
        Mode = md; A = NW'(a); B = NW'(b); CB_in = cbi; Use_flag_cb = uf; in_valid = 1'b1;
        while (!in_ready && cyc < 3*NW) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready got %0b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        cin = uf ? int'(m_c) : int'(cbi);
        exp_q.push_back(model(int'(md), a, b, cin));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    exp_t mon_got, mon_exp;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_checks++;
            mon_got = {Result_hi, Result, CB_out, Zero, Neg, Ovf};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: got %0h, expected no output", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL scoreboard {hi,res,C,Z,N,V}: got %0h, expected %0h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {out_valid, Result, Result_hi, CB_out, Zero, Neg, Ovf}, 0);
        chk("reset_in_ready", in_ready, 1);

        // ADD wrap to zero with carry, one-cycle out_valid pulse
        send(4'h0, 15, 1, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_flags", {out_valid, Result, CB_out, Zero, Neg, Ovf}, {1'b1, 4'b0000, 4'b1100});
        @(negedge clk);
        chk("add_pulse", out_valid, 0);

        send(4'h1, 7, 8, 1'b0, 1'b0);
        @(negedge clk);
        chk("sub_ovf", {Result, CB_out, Neg, Ovf}, {4'b1111, 3'b111});
        send(4'h1, 0, 1, 1'b0, 1'b0);
        @(negedge clk);
        chk("sub_borrow", {Result, CB_out, Ovf}, {4'b1111, 2'b10});

        // Carry chaining on consecutive accepts
        send(4'h0, 15, 1, 1'b0, 1'b0);
        send(4'h0, 2, 4, 1'b0, 1'b1);
        @(negedge clk);
        chk("chain", {Result, CB_out}, {4'b0111, 1'b0});

        // MUL busy window with operands churning underneath
        send(4'hD, 15, 13, 1'b0, 1'b0);
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 3*NW) begin
            A = NW'($urandom); B = NW'($urandom);
            cnt++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", cnt, NW);
        chk("mul_result", {out_valid, Result_hi, Result, CB_out, Zero, Neg}, {1'b1, 4'b1100, 4'b0011, 3'b101});

        // Reset on the second multiply step aborts it
        send(4'hD, 15, 13, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        m_res = 0; m_hi = 0; m_c = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midmul_reset_outputs", {out_valid, Result, Result_hi, CB_out, Zero, Neg, Ovf}, 0);
        chk("midmul_reset_ready", in_ready, 1);
        for (int i = 0; i < NW + 2; i++) begin
            @(negedge clk);
            chk("midmul_no_valid", out_valid, 0);
        end
        send(4'h6, 15, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("inc_wrap", {Result, CB_out}, {4'b0000, 1'b1});

        // CMP leaves Result untouched, then ROL through carry
        send(4'hF, 0, 10, 1'b0, 1'b0);
        send(4'hE, 2, 4, 1'b0, 1'b0);
        @(negedge clk);
        chk("cmp_hold", {Result, Result_hi, CB_out, Neg, Zero}, {4'b1010, 4'b0000, 3'b110});
        send(4'hB, 8, 0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rol", {Result, CB_out}, {4'b0001, 1'b1});

        for (int i = 0; i < 400; i++) begin
            send(4'($urandom_range(0, 15)), int'($urandom_range(0, M-1)), int'($urandom_range(0, M-1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_n_bit.md
Name: alu_seq_n_bit

Overview:
- Registered, parametrised successor to the combinational n-bit ALU.
- Keeps the eight original operations and adds shifts, rotates-through-carry, compare, pass-B and an iterative unsigned multiply.
- Adds a valid/ready input handshake, a persistent status-flag register (C, Z, N, V) and carry/borrow chaining for multi-word arithmetic.
- Sits between the operand register file and the writeback stage of the datapath.

Parameters:
N, 8, operand and result width in bits (N >= 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operands/Mode valid
in_ready  output  1  block can accept an operation this cycle
A  input  N  operand A
B  input  N  operand B
CB_in  input  1  external carry-in/borrow-in
Use_flag_cb  input  1  1: use stored C flag instead of CB_in
Mode  input  4  operation select
out_valid  output  1  one-cycle pulse: Result/flags updated this cycle
Result  output  N  result (low half for MUL)
Result_hi  output  N  high half of MUL product, 0 for all other ops
CB_out  output  1  carry/borrow/shift-out flag (C)
Zero  output  1  Z flag
Neg  output  1  N flag
Ovf  output  1  signed overflow flag (V)

Behaviour:
- Reset (rst_n=0 at a clk edge): Result, Result_hi, CB_out, Zero, Neg, Ovf, out_valid all 0; FSM to IDLE; in_ready=1 from the first cycle after reset. Reset mid-MUL aborts the operation; no out_valid is produced.
- Accept: on an edge where in_valid && in_ready. A, B, Mode and the effective carry cin (Use_flag_cb ? CB_out : CB_in) are captured. Inputs are ignored at any other time.
- FSM states:
  - IDLE (in_ready=1): single-cycle op accepted -> outputs and flags written at the same edge, out_valid=1 the following cycle. Latency is 1, and back-to-back accepts every cycle are allowed.
  - MUL accepted in IDLE -> MUL.
  - MUL (in_ready=0): one shift-add step per edge for N edges. The edge of the N-th step writes the outputs with out_valid=1 and returns the FSM to IDLE. in_ready is low for exactly N cycles.
- Modes (cin = effective carry):
  - 0000 ADD: {C,R} = A+B+cin
  - 0001 SUB: R = A-B-cin mod 2^N; C = borrow (1 iff A < B+cin)
  - 0010 AND, 0011 OR, 0100 XOR
  - 0101 NOT A
  - 0110 INC: A+1, C=carry
  - 0111 DEC: A-1, C=borrow
  - 1000 SHL: R = A<<1, C = A[N-1]
  - 1001 SHR: logical, C = A[0]
  - 1010 ASR: arithmetic, C = A[0]
  - 1011 ROL: {C,R} = {A,cin}
  - 1100 ROR: {R,C} = {cin,A}
  - 1101 MUL: {Result_hi,Result} = A*B unsigned; C = |Result_hi
  - 1110 CMP: flags exactly as SUB; Result and Result_hi hold previous values
  - 1111 PASS: R = B
- Flags on every completed op:
  - Z = (Result==0), or (product==0) for MUL; for CMP, Z = (difference==0).
  - N = MSB of Result, or of Result_hi for MUL, or of the difference for CMP.
  - V = two's-complement overflow for ADD/SUB/INC/DEC/CMP; 0 otherwise.
  - C = 0 for AND/OR/XOR/NOT/PASS.
- All outputs hold their values between completions. Result_hi is cleared to 0 by every non-MUL, non-CMP completion.
- Simultaneous events: rst_n=0 takes priority over accept and MUL completion. in_valid during MUL is not accepted and must be held by the source.

Test Plan (N=4):
- ADD A=1111 B=0001 CB_in=0 accepted at edge k -> at edge k+1: Result=0000, CB_out=1, Zero=1, Neg=0, Ovf=0, out_valid=1 for one cycle.
- SUB A=0111 B=1000 CB_in=0 -> Result=1111, CB_out=1, Neg=1, Ovf=1. Then SUB A=0000 B=0001 -> Result=1111, CB_out=1, Ovf=0.
- Chaining: ADD 1111+0001 (C=1), then ADD A=0010 B=0100 Use_flag_cb=1 CB_in=0 on the next cycle -> Result=0111, CB_out=0. Accepts occur on consecutive cycles.
- MUL A=1111 B=1101 -> in_ready=0 for 4 cycles; A/B changes during that window are ignored. out_valid after the 4th step with Result_hi=1100, Result=0011, CB_out=1, Zero=0, Neg=1.
- Reset mid-MUL: rst_n=0 on the 2nd step edge -> next cycle all outputs 0, in_ready=1, no out_valid afterwards. A fresh INC A=1111 then gives Result=0000, CB_out=1.
- After PASS B=1010, CMP A=0010 B=0100 -> Result holds 1010, CB_out=1, Neg=1, Zero=0. Then ROL A=1000 CB_in=1 -> Result=0001, CB_out=1.
